// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
// ------------------
// A 32 x 32-bit MIPS general-purpose register file with a per-register busy
// scoreboard. Decode uses it to read operands and to stall on RAW hazards.
// Register ZERO_REG always reads as zero and never goes busy. Writeback data
// is bypassed to both read ports in the same cycle it is written.
//
// Ports:
//   clk        system clock; all state updates on the rising edge
//   reset      asynchronous, active-high; clears all registers and busy bits
//   ra1/ra2    read port addresses
//   rd1/rd2    read port data (combinational, with writeback bypass)
//   rdy1/rdy2  read port operand ready (register not pending)
//   we/wa/wd   writeback enable, address and data
//   set_busy   issue strobe: mark busy_addr as pending
//   busy_addr  destination register of the issuing instruction
//   flush      pipeline flush: clear all busy bits
//   any_busy   OR of all busy bits (registered state only)
module regfile_scoreboard #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] ra1,
  output logic [DW-1:0] rd1,
  output logic          rdy1,
  input  logic [AW-1:0] ra2,
  output logic [DW-1:0] rd2,
  output logic          rdy2,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic          set_busy,
  input  logic [AW-1:0] busy_addr,
  input  logic          flush,
  output logic          any_busy
);

  localparam int NumRegs = 2 ** AW;
  localparam logic [AW-1:0] ZeroAddr = AW'(ZERO_REG);

  logic [DW-1:0]      regs_q [NumRegs];
  logic [NumRegs-1:0] busy_q;
  logic [NumRegs-1:0] busy_d;

  logic writeValid;
  logic setValid;

  assign writeValid = we && (wa != ZeroAddr);
  assign setValid   = set_busy && (busy_addr != ZeroAddr);

  // Register storage. Writes to the zero register are dropped so it stays 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= '0;
      end
    end else if (writeValid) begin
      regs_q[wa] <= wd;
    end
  end

  // Busy next state. The clear from writeback is applied before the set from
  // issue so that a newer instruction targeting the same register keeps it
  // pending. Flush squashes everything, including a same-cycle issue.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (writeValid) begin
        busy_d[wa] = 1'b0;
      end
      if (setValid) begin
        busy_d[busy_addr] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Read ports: zero register first, then writeback bypass, then storage.
  // A bypassed operand is ready even if its busy bit is still set.
  always_comb begin
    rd1  = regs_q[ra1];
    rdy1 = !busy_q[ra1];
    if (ra1 == ZeroAddr) begin
      rd1  = '0;
      rdy1 = 1'b1;
    end else if (we && (wa == ra1)) begin
      rd1  = wd;
      rdy1 = 1'b1;
    end
  end

  always_comb begin
    rd2  = regs_q[ra2];
    rdy2 = !busy_q[ra2];
    if (ra2 == ZeroAddr) begin
      rd2  = '0;
      rdy2 = 1'b1;
    end else if (we && (wa == ra2)) begin
      rd2  = wd;
      rdy2 = 1'b1;
    end
  end

  assign any_busy = |busy_q;

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
32 x 32-bit MIPS general-purpose register file with two combinational read ports, one synchronous write port and write-to-read bypass. It also holds a per-register busy scoreboard. Decode sets a destination pending when an instruction issues, and writeback clears it when the result is written. Decode reads operands and ready flags here, and uses the ready flags to stall on RAW hazards.

Parameters:
DW, 32, data width of each register
AW, 5, register address width; register count is 2**AW
ZERO_REG, 0, index of hardwired-zero register

Ports:
clk  input  1  system clock; all state updates on posedge
reset  input  1  asynchronous, active-high; clears all registers and busy bits
ra1  input  AW  read port 1 address
rd1  output  DW  read port 1 data
rdy1  output  1  read port 1 operand ready (not pending)
ra2  input  AW  read port 2 address
rd2  output  DW  read port 2 data
rdy2  output  1  read port 2 operand ready
we  input  1  write enable (writeback)
wa  input  AW  write address
wd  input  DW  write data
set_busy  input  1  issue: mark busy_addr pending
busy_addr  input  AW  destination register of issuing instruction
flush  input  1  pipeline flush: clear all busy bits
any_busy  output  1  OR of all busy bits

Behaviour:
- Reset (async, active-high, independent of clk): all registers = 0, all busy bits = 0. Outputs during/after reset: rd1 = rd2 = 0 unless bypassed, rdy1 = rdy2 = 1, any_busy = 0. Reset asserted mid-operation overrides any same-cycle we, set_busy or flush.
- Write: at posedge, if we and wa != ZERO_REG, then reg[wa] <= wd. A write to ZERO_REG is discarded.
- Read (combinational, zero latency):
  - rdN = 0 if raN == ZERO_REG.
  - Otherwise rdN = wd if we and wa == raN (same-cycle bypass).
  - Otherwise rdN = reg[raN].
- Ready (combinational):
  - rdyN = 1 if raN == ZERO_REG.
  - Otherwise rdyN = 1 if we and wa == raN (bypassed result is available).
  - Otherwise rdyN = !busy[raN].
- Busy update at posedge, in priority order:
  1. flush: all busy bits <= 0. flush takes priority over set_busy in the same cycle because the issuing instruction is squashed too. A same-cycle we still writes the register.
  2. set_busy and busy_addr != ZERO_REG: busy[busy_addr] <= 1. If we and wa == busy_addr in the same cycle, set wins: the register stays busy for the newer instruction, and the data is still written.
  3. we and wa != ZERO_REG (and not re-set by rule 2): busy[wa] <= 0.
- busy[ZERO_REG] is never set.
- A write to a register that is not busy is legal; it writes the data and busy stays 0.
- set_busy on a register that is already busy is legal and leaves it busy (no counting).
- any_busy is registered-state only: the OR of current busy bits, with no combinational path from inputs.
- The two read ports are fully independent; ra1 == ra2 is legal and returns identical values.

Test Plan:
- Reset then read: assert reset asynchronously between edges, deassert, ra1 = 5, ra2 = 31 -> rd1 = rd2 = 0, rdy1 = rdy2 = 1, any_busy = 0.
- Write/read and zero reg:
  - we = 1, wa = 7, wd = 0xDEADBEEF -> rd1 = 0xDEADBEEF in the same cycle (bypass) and after the edge.
  - we = 1, wa = 0, wd = 0x12345678 -> ra1 = 0 reads 0.
- Scoreboard RAW:
  - set_busy = 1, busy_addr = 9 -> next cycle ra1 = 9 gives rdy1 = 0, any_busy = 1.
  - Later we = 1, wa = 9, wd = 0xA5A5A5A5 -> rdy1 = 1 and rd1 = 0xA5A5A5A5 combinationally that cycle; after the edge busy[9] = 0 and any_busy = 0.
- Simultaneous set and clear: busy[3] = 1; in the same cycle we = 1, wa = 3, wd = 0x11, set_busy = 1, busy_addr = 3 -> after the edge reg[3] = 0x11 and rdy for ra = 3 is 0.
- Flush:
  - Busy regs 4, 6, 8 -> flush = 1 with set_busy = 1, busy_addr = 10 -> after the edge any_busy = 0 and rdy for 4, 6, 8 and 10 are all 1.
  - Reset mid-operation: reset asserted while we = 1, wa = 2 -> reg[2] reads 0 after reset and any_busy = 0.
